sat_counter_table: RTL and testbench
====================================

# sat_counter_table

Parametrised table of saturating branch-direction counters, with one synchronous read (predict) port and one increment/decrement (train) port. Sits in the front end's direction predictor, indexed by the hashed fetch PC. Generalises the fixed 256×3 counter memory with:
- configurable width and depth;
- in-block saturating read-modify-write;
- a hardware init sweep with software-triggered clear;
- optional update-to-read bypass.

## Interface
Parameters:
- CTR_WIDTH, 3, counter bits; MSB is the predicted direction (1 = taken)
- NUM_ENTRIES, 256, table depth; power of two, ≥ 4
- IDX_WIDTH, $clog2(NUM_ENTRIES), index width (derived, not overridden)
- INIT_VALUE, 1 << (CTR_WIDTH-1), reset/clear value (weakly taken)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous request to re-run the init sweep
- ready  output  1  table initialised; read/update accepted only when high
- rd_en  input  1  read request
- rd_idx  input  IDX_WIDTH  read index
- rd_data  output  CTR_WIDTH  registered counter value
- rd_pred  output  1  rd_data[CTR_WIDTH-1]
- upd_en  input  1  update request
- upd_idx  input  IDX_WIDTH  update index
- upd_taken  input  1  1 = increment, 0 = decrement

## Operation
FSM states:
- **INIT**: entered on rst, or on clr sampled high in any state.
  - Walks a sweep pointer from 0 to NUM_ENTRIES-1, writing INIT_VALUE to one entry per cycle.
  - After the last entry is written, moves to RUN.
- **RUN**: ready=1. Reads and updates are served.

Reset values:
- ready=0; rd_data=0; sweep pointer=0; update pipeline valid=0; state=INIT.

Behaviour in INIT:
- rd_en and upd_en are ignored.
- rd_data holds its value.

Update pipeline (two stages):
- Cycle N: accept (upd_en & ready) and register idx/taken into stage S1.
- Cycle N+1: S1 reads the old value, computes the new value and writes the array at the end of N+1.
- Saturating arithmetic:
  - taken: new = (old == 2^CTR_WIDTH-1) ? old : old+1
  - not taken: new = (old == 0) ? 0 : old-1
  - No wrap-around in either direction.
- Back-to-back updates to the same index (accepted at N and N+1): the N+1 computation uses the value written by N, not the array contents. This internal forwarding is always present, so k consecutive updates move the counter by exactly k steps, saturation permitting.

Read port:
- rd_en & ready at cycle N: rd_data/rd_pred valid after the edge ending N (1-cycle latency).
- rd_en low: rd_data holds its value.

Simultaneous events:
- Read and update to the same index in the same cycle: the read returns the pre-update value.
- clr together with upd_en: clr wins; the update and any S1 update in flight are dropped, and ready falls the next cycle.
- rst mid-sweep or mid-update: immediate return to reset values; the sweep restarts from 0.

## Timing
- Init: rst deasserts before edge 1. Entry k is written at edge k+1. ready rises after edge NUM_ENTRIES (256 cycles by default).
- clr high at cycle N: ready=0 from N+1. Ready again after NUM_ENTRIES further cycles.
- Read latency: 1 cycle. Update commit latency: 2 edges after acceptance.
- One read and one update can be accepted per cycle, with no stalls in RUN.

## Configuration
- Macro SAT_COUNTER_TABLE_BYPASS_EN.
- **Defined**: a read at cycle N forwards the S1 result when S1 holds the same index. rd_data reflects every update accepted at cycles ≤ N-1.
- **Undefined**: no bypass path. rd_data reflects only updates accepted at cycles ≤ N-2; an update accepted at N-1 is invisible to the read at N.

## Test plan
- **Reset/init**: release rst, then count cycles → ready=1 exactly after 256 edges. Reads of indices 0, 17 and 255 return 3'b100 with rd_pred=1.
- **Saturation**: 5 taken updates to idx 9 → reads 5, 6, 7, 7, 7. Then 9 not-taken updates → final read 0, never wrapping to 7.
- **Back-to-back forwarding**: upd_en on 3 consecutive cycles to idx 3, taken → read afterwards returns 7 (not 5).
- **Bypass**: update idx 40 taken at N, read idx 40 at N+1.
  - Macro defined → rd_data=5.
  - Macro undefined → rd_data=4.
  - Read at N+2 → 5 in both builds.
- **Clear vs update**: counter idx 2 = 6; assert clr with upd_en idx 2 taken → ready=0 next cycle. After 256 cycles, idx 2 reads 4.
- **Mid-sweep reset**: pulse rst at init cycle 100 → ready stays 0 until 256 cycles after the second rst deassertion. All entries read 4.

Source files
------------

// File: rtl/sat_counter_table.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter_table
// Purpose  : Table of saturating branch-direction counters with one
//            registered read (predict) port and one two-stage saturating
//            read-modify-write (train) port. A hardware sweep initialises
//            every entry after reset or a synchronous clear.
// Options  : SAT_COUNTER_TABLE_BYPASS_EN - forwards the in-flight update
//            result to a read of the same index in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter_table #(
    parameter int                   CTR_WIDTH   = 3,
    parameter int                   NUM_ENTRIES = 256,
    parameter int                   IDX_WIDTH   = $clog2(NUM_ENTRIES),
    parameter logic [CTR_WIDTH-1:0] INIT_VALUE  = {1'b1, {(CTR_WIDTH-1){1'b0}}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    output logic                 ready,
    input  logic                 rd_en,
    input  logic [IDX_WIDTH-1:0] rd_idx,
    output logic [CTR_WIDTH-1:0] rd_data,
    output logic                 rd_pred,
    input  logic                 upd_en,
    input  logic [IDX_WIDTH-1:0] upd_idx,
    input  logic                 upd_taken
);

    localparam logic [0:0]           c_ST_INIT  = 1'b0;
    localparam logic [0:0]           c_ST_RUN   = 1'b1;
    localparam logic [CTR_WIDTH-1:0] c_CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] c_CTR_MIN  = '0;
    localparam logic [CTR_WIDTH-1:0] c_CTR_ONE  = CTR_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] c_IDX_ONE  = IDX_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(NUM_ENTRIES - 1);

    logic [0:0]           r_state;
    logic [IDX_WIDTH-1:0] r_sweep_ptr;
    logic                 r_ready;
    logic [CTR_WIDTH-1:0] r_rd_data;

    logic                 r_s1_valid;
    logic [IDX_WIDTH-1:0] r_s1_idx;
    logic                 r_s1_taken;

    logic [CTR_WIDTH-1:0] r_mem [NUM_ENTRIES];

    logic                 w_upd_accept;
    logic                 w_rd_accept;
    logic                 w_s1_commit;
    logic [CTR_WIDTH-1:0] w_s1_old;
    logic [CTR_WIDTH-1:0] w_s1_new;
    logic [CTR_WIDTH-1:0] w_rd_value;

    // A clear in the same cycle discards both the new request and the S1 write.
    assign w_upd_accept = upd_en & r_ready & ~clr;
    assign w_s1_commit  = r_s1_valid & ~clr;
    assign w_rd_accept  = rd_en & r_ready;

    // The array is read asynchronously, so an S1 write at the end of cycle N
    // is already visible to the S1 computation at N+1; back-to-back updates
    // to one index therefore chain without a separate forwarding register.
    assign w_s1_old = r_mem[r_s1_idx];

    // Saturating increment/decrement of the in-flight counter.
    always_comb begin
        w_s1_new = w_s1_old;
        if (r_s1_taken) begin
            if (w_s1_old != c_CTR_MAX) begin
                w_s1_new = w_s1_old + c_CTR_ONE;
            end
        end else begin
            if (w_s1_old != c_CTR_MIN) begin
                w_s1_new = w_s1_old - c_CTR_ONE;
            end
        end
    end

    // Read source: array contents, optionally overridden by the S1 result.
    always_comb begin
        w_rd_value = r_mem[rd_idx];
`ifdef SAT_COUNTER_TABLE_BYPASS_EN
        if (w_s1_commit && (r_s1_idx == rd_idx)) begin
            w_rd_value = w_s1_new;
        end
`endif
    end

    // Init/run sequencing: sweep pointer walks the table, then ready is raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_INIT;
            r_sweep_ptr <= '0;
            r_ready     <= 1'b0;
        end else if (clr) begin
            r_state     <= c_ST_INIT;
            r_sweep_ptr <= '0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_INIT: begin
                    r_sweep_ptr <= r_sweep_ptr + c_IDX_ONE;
                    if (r_sweep_ptr == c_LAST_IDX) begin
                        r_state <= c_ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Update stage S1: captures an accepted train request for the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_taken <= 1'b0;
        end else begin
            r_s1_valid <= w_upd_accept;
            if (w_upd_accept) begin
                r_s1_idx   <= upd_idx;
                r_s1_taken <= upd_taken;
            end
        end
    end

    // Single array write port: sweep writes during init, S1 result in run.
    always_ff @(posedge clk) begin
        if (r_state == c_ST_INIT) begin
            r_mem[r_sweep_ptr] <= INIT_VALUE;
        end else if (w_s1_commit) begin
            r_mem[r_s1_idx] <= w_s1_new;
        end
    end

    // Registered read port; holds its value when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (w_rd_accept) begin
            r_rd_data <= w_rd_value;
        end
    end

    assign ready   = r_ready;
    assign rd_data = r_rd_data;
    assign rd_pred = r_rd_data[CTR_WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_sat_counter_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_sat_counter_table
// Purpose  : Self-checking bench for sat_counter_table (default parameters).
//            Reference model: an integer array plus a queue of accepted
//            updates, each applied once its visibility delay has elapsed.
//            Honours SAT_COUNTER_TABLE_BYPASS_EN for the read visibility lag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sat_counter_table;

    localparam int c_CTR_W   = 3;
    localparam int c_ENTRIES = 256;
    localparam int c_CMAX    = 7;
    localparam int c_INITV   = 4;
`ifdef SAT_COUNTER_TABLE_BYPASS_EN
    localparam int c_LAG     = 1;
    localparam int c_BYP_EXP = 5;
`else
    localparam int c_LAG     = 2;
    localparam int c_BYP_EXP = 4;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               clr;
    logic               ready;
    logic               rd_en;
    logic [7:0]         rd_idx;
    logic [c_CTR_W-1:0] rd_data;
    logic               rd_pred;
    logic               upd_en;
    logic [7:0]         upd_idx;
    logic               upd_taken;

    sat_counter_table dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .ready     (ready),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_pred   (rd_pred),
        .upd_en    (upd_en),
        .upd_idx   (upd_idx),
        .upd_taken (upd_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit taken;
        int cyc;
    } upd_t;

    int   model [c_ENTRIES];
    upd_t pend [$];
    int   cyc;
    int   exp_rd;
    int   tests;
    int   fails;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < c_ENTRIES; i++) model[i] = c_INITV;
        pend.delete();
    endtask

    // Waits for ready with a cycle bound; returns the number of edges taken.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (ready !== 1'b1 && cnt < 600) begin
            tick();
            cnt++;
        end
    endtask

    // One run-mode cycle: drive, predict from the model, clock, check.
    task automatic do_cycle(input bit re, input int ri, input bit ue, input int ui, input bit ut);
        upd_t u;
        rd_en     = re;
        rd_idx    = 8'(ri);
        upd_en    = ue;
        upd_idx   = 8'(ui);
        upd_taken = ut;
        while (pend.size() > 0 && pend[0].cyc <= cyc - c_LAG) begin
            u = pend.pop_front();
            if (u.taken) model[u.idx] = (model[u.idx] >= c_CMAX) ? c_CMAX : model[u.idx] + 1;
            else         model[u.idx] = (model[u.idx] <= 0) ? 0 : model[u.idx] - 1;
        end
        if (re) exp_rd = model[ri];
        if (ue) begin
            u.idx = ui; u.taken = ut; u.cyc = cyc;
            pend.push_back(u);
        end
        tick();
        cyc++;
        rd_en  = 1'b0;
        upd_en = 1'b0;
        check("rd_data_model", 32'(rd_data), 32'(exp_rd));
        check("rd_pred_model", 32'(rd_pred), 32'(exp_rd >> 2));
    endtask

    int cnt;
    int sat_seq [5] = '{5, 6, 7, 7, 7};

    initial begin
        tests = 0; fails = 0; cyc = 0; exp_rd = 0;
        rst = 1'b1; clr = 1'b0; rd_en = 1'b0; rd_idx = '0;
        upd_en = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        model_reset();

        // Reset state
        repeat (3) tick();
        check("reset_ready", 32'(ready), 0);
        check("reset_rd_data", 32'(rd_data), 0);

        // Init sweep length
        rst = 1'b0;
        wait_ready(cnt);
        check("init_cycles", cnt, c_ENTRIES);

        // Initial contents
        do_cycle(1, 0, 0, 0, 0);   check("init_idx0", 32'(rd_data), 4);
        do_cycle(1, 17, 0, 0, 0);  check("init_idx17", 32'(rd_data), 4);
        do_cycle(1, 255, 0, 0, 0); check("init_idx255", 32'(rd_data), 4);
        check("init_pred", 32'(rd_pred), 1);

        // Saturation upward then downward on idx 9
        for (int i = 0; i < 5; i++) begin
            do_cycle(0, 0, 1, 9, 1);
            do_cycle(0, 0, 0, 0, 0);
            do_cycle(1, 9, 0, 0, 0);
            check("sat_up", 32'(rd_data), 32'(sat_seq[i]));
        end
        for (int i = 0; i < 9; i++) do_cycle(0, 0, 1, 9, 0);
        do_cycle(0, 0, 0, 0, 0);
        do_cycle(1, 9, 0, 0, 0);
        check("sat_down", 32'(rd_data), 0);

        // Back-to-back updates to one index
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 1, 3, 1);
        do_cycle(0, 0, 0, 0, 0);
        do_cycle(1, 3, 0, 0, 0);
        check("b2b_fwd", 32'(rd_data), 7);

        // Update-to-read bypass
        do_cycle(0, 0, 1, 40, 1);
        do_cycle(1, 40, 0, 0, 0);
        check("bypass_n1", 32'(rd_data), 32'(c_BYP_EXP));
        do_cycle(1, 40, 0, 0, 0);
        check("bypass_n2", 32'(rd_data), 5);

        // Same-cycle read and update return the pre-update value
        do_cycle(1, 50, 1, 50, 1);
        check("same_cycle", 32'(rd_data), 4);
        do_cycle(0, 0, 0, 0, 0);
        do_cycle(1, 50, 0, 0, 0);
        check("same_cycle_after", 32'(rd_data), 5);

        // Clear wins over a simultaneous update; init ignores reads/updates
        do_cycle(0, 0, 1, 2, 1);
        do_cycle(0, 0, 1, 2, 1);
        do_cycle(0, 0, 0, 0, 0);
        do_cycle(1, 2, 0, 0, 0);
        check("clr_pre", 32'(rd_data), 6);
        clr = 1'b1; upd_en = 1'b1; upd_idx = 8'd2; upd_taken = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_ready_low", 32'(ready), 0);
        rd_en = 1'b1; rd_idx = 8'd7; upd_idx = 8'd7;
        wait_ready(cnt);
        rd_en = 1'b0; upd_en = 1'b0;
        check("clr_cycles", cnt, c_ENTRIES);
        check("init_rd_hold", 32'(rd_data), 32'(exp_rd));
        model_reset();
        do_cycle(1, 2, 0, 0, 0); check("clr_idx2", 32'(rd_data), 4);
        do_cycle(1, 7, 0, 0, 0); check("init_upd_ignored", 32'(rd_data), 4);

        // Reset in the middle of a sweep
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        #1;
        check("async_rst_rd", 32'(rd_data), 0);
        check("async_rst_ready", 32'(ready), 0);
        tick();
        rst = 1'b0;
        exp_rd = 0;
        model_reset();
        wait_ready(cnt);
        check("rst_mid_cycles", cnt, c_ENTRIES);
        for (int i = 0; i < c_ENTRIES; i++) do_cycle(1, i, 0, 0, 0);

        // Randomised traffic over a small index window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
